rv_mem: RTL and testbench
=========================

RV_MEM -- requirements
Module: rv_mem

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, max cycles in WAIT before abort (used only under REQ-031).
REQ-002 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 valid_Q103H  in  1  instruction present in Q103H.
REQ-005 mem_rd_Q103H / mem_wr_Q103H  in  1 each  load / store.
REQ-006 mem_size_Q103H  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-007 mem_unsigned_Q103H  in  1  zero-extend load.
REQ-008 alu_out_Q103H, dmem_wr_data_Q103H, pc_plus4_Q103H  in  32 each  address, store data, link value.
REQ-009 sel_wb_Q103H  in  2  00 ALU, 01 MEM, 10 PC+4.
REQ-010 rd_Q103H  in  5; reg_write_en_Q103H  in  1.
REQ-011 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32, word-aligned; dmem_be  out  4; dmem_wdata  out  32.
REQ-012 dmem_ack  in  1; dmem_rdata  in  32  valid only with ack.
REQ-013 ready_Q103H  out  1  0 stalls Q100H..Q103H.
REQ-014 wb_data_Q103H  out  32  combinational result, feeds forwarding.
REQ-015 wb_data_Q104H  out  32; rd_Q104H  out  5; reg_write_en_Q104H  out  1.
REQ-016 misaligned_Q103H  out  1; err_timeout_Q103H  out  1.

Function
REQ-017 Access pending = valid & (mem_rd | mem_wr) & aligned; aligned = word addr[1:0]==0, half addr[0]==0, byte always.
REQ-018 FSM states IDLE, WAIT; IDLE: pending & ack -> IDLE; pending & !ack -> WAIT; WAIT: ack -> IDLE, else WAIT.
REQ-019 dmem_req = pending in IDLE, 1 in WAIT; zero-wait ack in request cycle completes access.
REQ-020 dmem_we = mem_wr while dmem_req; dmem_addr = {alu_out[31:2],2'b00}.
REQ-021 Store data: byte {4{d[7:0]}}, be 0001<<addr[1:0]; half {2{d[15:0]}}, be 0011<<addr[1:0]; word d, be 1111.
REQ-022 Load: select lane by addr[1:0], sign-extend unless mem_unsigned; word passes dmem_rdata unchanged.
REQ-023 wb_data_Q103H = ALU/MEM(extracted)/PC+4 per sel_wb; MEM value meaningful only in ack cycle.
REQ-024 ready_Q103H = !pending | dmem_ack (excluding REQ-031 abort).
REQ-025 Q104H registers load wb_data_Q103H, rd_Q103H, reg_write_en_Q103H & valid & !misaligned & !timeout when ready_Q103H=1; hold when 0.
REQ-026 Misaligned access: misaligned_Q103H=1 same cycle, no dmem_req, ready_Q103H=1, writeback suppressed.
REQ-027 Upstream inputs SHALL be stable during stall; address/data/be SHALL stay constant across WAIT.
REQ-028 Latency: load result in wb_data_Q104H one cycle after ack.

Reset
REQ-029 On rst: state IDLE, wb_data_Q104H=0, rd_Q104H=0, reg_write_en_Q104H=0, timeout counter=0; dmem_req=0 cycle after reset edge.
REQ-030 Reset during WAIT abandons access; memory side SHALL tolerate dropped request; late ack in IDLE with no pending access is ignored.

Configuration
REQ-031 With RV_MEM_TIMEOUT_EN defined: counter increments each WAIT cycle without ack; at TIMEOUT_CYC, err_timeout_Q103H=1 for one cycle, ready_Q103H=1, writeback suppressed, state -> IDLE, counter cleared.
REQ-032 Without RV_MEM_TIMEOUT_EN: no counter, err_timeout_Q103H tied 0, WAIT indefinite.

Verification
REQ-033 Load word addr 0x100, ack same cycle, rdata 0xDEADBEEF -> ready=1, next cycle wb_data_Q104H=0xDEADBEEF.
REQ-034 Load byte signed addr 0x103, ack after 3 cycles, rdata 0x80112233 -> ready=0 three cycles, wb_data_Q104H=0xFFFFFF80, addr held 0x100.
REQ-035 Store half addr 0x202, data 0x0000ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
REQ-036 Load word addr 0x101 -> misaligned=1, dmem_req=0, reg_write_en_Q104H=0.
REQ-037 rst during WAIT -> next cycle dmem_req=0, reg_write_en_Q104H=0; late ack ignored.
REQ-038 RV_MEM_TIMEOUT_EN, TIMEOUT_CYC=4, no ack -> err_timeout pulse after 4 WAIT cycles, ready=1, FSM IDLE.

Source files
------------

// File: rtl/rv_mem.sv
// -----------------------------------------------------------------------------
// rv_mem -- Q103H memory stage of an RV32 pipeline.
//
// This stage issues data-memory loads and stores and packs store data into
// byte lanes. It also extracts and sign- or zero-extends load data, selects
// the writeback value, and registers the Q104H writeback stage. A two-state
// FSM (IDLE/WAIT) tracks accesses that are not acknowledged in the request
// cycle, and ready_Q103H stalls Q100H..Q103H while such an access is
// outstanding.
//
// Optional feature (compile-time macro RV_MEM_TIMEOUT_EN):
//   When the macro is defined, a watchdog aborts an access that has spent
//   TIMEOUT_CYC WAIT cycles without an ack. When it is undefined, the WAIT
//   state can last indefinitely and err_timeout_Q103H is tied to 0.
//
// Parameters
//   TIMEOUT_CYC          WAIT cycles without an ack before the watchdog aborts
//                        (used only with RV_MEM_TIMEOUT_EN)
// Ports
//   clk, rst             clock, synchronous active-high reset
//   valid_Q103H          instruction present in Q103H
//   mem_rd/mem_wr_Q103H  load / store
//   mem_size_Q103H       00 byte, 01 half, 10/11 word
//   mem_unsigned_Q103H   zero-extend load data
//   alu_out_Q103H        effective address / ALU result
//   dmem_wr_data_Q103H   store data (unaligned, low bits)
//   pc_plus4_Q103H       link value
//   sel_wb_Q103H         00 ALU, 01 MEM, 10 PC+4
//   rd_Q103H, reg_write_en_Q103H   destination register and write enable
//   dmem_*               data-memory request/response channel
//   ready_Q103H          0 stalls the upstream pipeline
//   wb_data_Q103H        combinational writeback value (forwarding source)
//   *_Q104H              registered writeback stage
//   misaligned_Q103H     misaligned access flag (access dropped)
//   err_timeout_Q103H    watchdog abort pulse
// -----------------------------------------------------------------------------
module rv_mem #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_Q103H,
  input  logic        mem_rd_Q103H,
  input  logic        mem_wr_Q103H,
  input  logic [1:0]  mem_size_Q103H,
  input  logic        mem_unsigned_Q103H,
  input  logic [31:0] alu_out_Q103H,
  input  logic [31:0] dmem_wr_data_Q103H,
  input  logic [31:0] pc_plus4_Q103H,
  input  logic [1:0]  sel_wb_Q103H,
  input  logic [4:0]  rd_Q103H,
  input  logic        reg_write_en_Q103H,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        ready_Q103H,
  output logic [31:0] wb_data_Q103H,
  output logic [31:0] wb_data_Q104H,
  output logic [4:0]  rd_Q104H,
  output logic        reg_write_en_Q104H,
  output logic        misaligned_Q103H,
  output logic        err_timeout_Q103H
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SEL_ALU   = 2'b00;
  localparam logic [1:0] SEL_MEM   = 2'b01;
  localparam logic [1:0] SEL_PC4   = 2'b10;

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  offset;
  logic        is_mem;
  logic        aligned;
  logic        pending;
  logic        active;
  logic        timeout;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign offset = alu_out_Q103H[1:0];
  assign is_mem = valid_Q103H & (mem_rd_Q103H | mem_wr_Q103H);

  // ---------------------------------------------------------------------------
  // Alignment check
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so that no path through the block can infer a latch.
    aligned = 1'b1;
    case (mem_size_Q103H)
      SIZE_BYTE: aligned = 1'b1;
      SIZE_HALF: aligned = ~offset[0];
      default:   aligned = (offset == 2'b00);
    endcase
  end

  assign pending          = is_mem & aligned;
  assign misaligned_Q103H = is_mem & ~aligned;

  // An access stays live through WAIT even though the upstream inputs are held
  // stable. Reset kills it immediately, so the request drops during reset.
  assign active = ~rst & ((state == WAIT) | pending);

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
`ifdef RV_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] to_cnt;

  // The counter holds the number of WAIT cycles already spent without an ack.
  // An ack that arrives in the same cycle as the limit still completes
  // normally.
  assign timeout = ~rst & (state == WAIT) & ~dmem_ack &
                   (to_cnt == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if ((state == WAIT) && !dmem_ack && !timeout) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout            = 1'b0;
`endif

  assign err_timeout_Q103H = timeout;

  // ---------------------------------------------------------------------------
  // FSM: state register + next state / handshake outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values regardless of block ordering.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dmem_req    = active;
    dmem_we     = active & mem_wr_Q103H;
    // A late ack with nothing outstanding is ignored: ready is already 1 then.
    ready_Q103H = ~active | dmem_ack | timeout;
    case (state)
      IDLE:    if (pending && !dmem_ack && !rst) state_nxt = WAIT;
      WAIT:    if (dmem_ack || timeout)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Store lane packing. Address, byte enables and data derive only from the
  // held Q103H inputs, so they stay constant across WAIT.
  // ---------------------------------------------------------------------------
  assign dmem_addr = {alu_out_Q103H[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = dmem_wr_data_Q103H;
    case (mem_size_Q103H)
      SIZE_BYTE: begin
        dmem_be    = 4'b0001 << offset;
        dmem_wdata = {4{dmem_wr_data_Q103H[7:0]}};
      end
      SIZE_HALF: begin
        dmem_be    = 4'b0011 << offset;
        dmem_wdata = {2{dmem_wr_data_Q103H[15:0]}};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load lane extraction and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (offset)
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = offset[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    ld_data = dmem_rdata;
    case (mem_size_Q103H)
      SIZE_BYTE: ld_data = mem_unsigned_Q103H ? {24'd0, ld_byte}
                                              : {{24{ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data = mem_unsigned_Q103H ? {16'd0, ld_half}
                                              : {{16{ld_half[15]}}, ld_half};
      default:   ld_data = dmem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Writeback select. The MEM value is only meaningful in the ack cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    wb_data_Q103H = alu_out_Q103H;
    case (sel_wb_Q103H)
      SEL_ALU: wb_data_Q103H = alu_out_Q103H;
      SEL_MEM: wb_data_Q103H = ld_data;
      SEL_PC4: wb_data_Q103H = pc_plus4_Q103H;
      default: wb_data_Q103H = alu_out_Q103H;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Q104H writeback registers: advance when Q103H retires, hold during stall
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data_Q104H      <= '0;
      rd_Q104H           <= '0;
      reg_write_en_Q104H <= 1'b0;
    end else if (ready_Q103H) begin
      wb_data_Q104H      <= wb_data_Q103H;
      rd_Q104H           <= rd_Q103H;
      reg_write_en_Q104H <= reg_write_en_Q103H & valid_Q103H &
                            ~misaligned_Q103H & ~timeout;
    end
  end

endmodule

// File: tb/tb_rv_mem.sv
// -----------------------------------------------------------------------------
// tb_rv_mem -- scoreboard testbench for rv_mem.
// Stimulus pushes expected writebacks and memory handshakes into queues; a
// monitor pops and compares them whenever the DUT retires a writeback or
// completes a memory handshake. Cycle-level properties are checked inline.
// -----------------------------------------------------------------------------
module tb_rv_mem;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] alu_out;
  logic [31:0] dmem_wr_data;
  logic [31:0] pc_plus4;
  logic [1:0]  sel_wb;
  logic [4:0]  rd;
  logic        reg_write_en;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        ready_Q103H;
  logic [31:0] wb_data_Q103H;
  logic [31:0] wb_data_Q104H;
  logic [4:0]  rd_Q104H;
  logic        reg_write_en_Q104H;
  logic        misaligned_Q103H;
  logic        err_timeout_Q103H;

  typedef struct {
    string       name;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_exp_t;

  wb_exp_t  wb_q[$];
  mem_exp_t mem_q[$];

  int checks = 0;
  int errors = 0;

  rv_mem #(.TIMEOUT_CYC(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .valid_Q103H        (valid),
    .mem_rd_Q103H       (mem_rd),
    .mem_wr_Q103H       (mem_wr),
    .mem_size_Q103H     (mem_size),
    .mem_unsigned_Q103H (mem_unsigned),
    .alu_out_Q103H      (alu_out),
    .dmem_wr_data_Q103H (dmem_wr_data),
    .pc_plus4_Q103H     (pc_plus4),
    .sel_wb_Q103H       (sel_wb),
    .rd_Q103H           (rd),
    .reg_write_en_Q103H (reg_write_en),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_be            (dmem_be),
    .dmem_wdata         (dmem_wdata),
    .dmem_ack           (dmem_ack),
    .dmem_rdata         (dmem_rdata),
    .ready_Q103H        (ready_Q103H),
    .wb_data_Q103H      (wb_data_Q103H),
    .wb_data_Q104H      (wb_data_Q104H),
    .rd_Q104H           (rd_Q104H),
    .reg_write_en_Q104H (reg_write_en_Q104H),
    .misaligned_Q103H   (misaligned_Q103H),
    .err_timeout_Q103H  (err_timeout_Q103H)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: writeback retirement and memory handshakes
  // ---------------------------------------------------------------------------
  initial begin
    logic     prev_ready;
    wb_exp_t  we_e;
    mem_exp_t me_e;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && prev_ready && reg_write_en_Q104H) begin
        if (wb_q.size() == 0) begin
          check("wb_unexpected", {31'd0, reg_write_en_Q104H}, 32'd0);
        end else begin
          we_e = wb_q.pop_front();
          check({we_e.name, ":wb_rd"},   {27'd0, rd_Q104H}, {27'd0, we_e.rd});
          check({we_e.name, ":wb_data"}, wb_data_Q104H,     we_e.data);
        end
      end
      if (!rst && dmem_req && dmem_ack) begin
        if (mem_q.size() == 0) begin
          check("mem_unexpected", {31'd0, dmem_req}, 32'd0);
        end else begin
          me_e = mem_q.pop_front();
          check({me_e.name, ":we"},    {31'd0, dmem_we}, {31'd0, me_e.we});
          check({me_e.name, ":addr"},  dmem_addr,        me_e.addr);
          check({me_e.name, ":be"},    {28'd0, dmem_be}, {28'd0, me_e.be});
          check({me_e.name, ":wdata"}, dmem_wdata,       me_e.wdata);
        end
      end
      prev_ready = ready_Q103H;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive_idle();
    valid        = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = 2'b10;
    mem_unsigned = 1'b0;
    alu_out      = 32'h0;
    dmem_wr_data = 32'h0;
    pc_plus4     = 32'h0;
    sel_wb       = 2'b00;
    rd           = 5'd0;
    reg_write_en = 1'b0;
    dmem_ack     = 1'b0;
    dmem_rdata   = 32'h0;
  endtask

  task automatic run_alu(input string name, input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [4:0] rd_i, input logic [31:0] exp);
    @(posedge clk); #1;
    drive_idle();
    valid        = 1'b1;
    sel_wb       = sel;
    alu_out      = alu;
    pc_plus4     = pc4;
    rd           = rd_i;
    reg_write_en = 1'b1;
    wb_q.push_back('{name, rd_i, exp});
    @(negedge clk);
    check({name, ":ready"},    {31'd0, ready_Q103H},      32'd1);
    check({name, ":req"},      {31'd0, dmem_req},         32'd0);
    check({name, ":misalign"}, {31'd0, misaligned_Q103H}, 32'd0);
    check({name, ":wb_q103"},  wb_data_Q103H,             exp);
  endtask

  task automatic run_mem(input string name, input logic wr, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rd_i, input logic rwe, input int wait_cyc,
                         input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_wb, input logic chk_hold,
                         input logic [31:0] hold_data);
    @(posedge clk); #1;
    drive_idle();
    valid        = 1'b1;
    mem_rd       = ~wr;
    mem_wr       = wr;
    mem_size     = size;
    mem_unsigned = uns;
    alu_out      = addr;
    dmem_wr_data = sdata;
    sel_wb       = 2'b01;
    rd           = rd_i;
    reg_write_en = rwe;
    mem_q.push_back('{name, wr, exp_addr, exp_be, exp_wdata});
    if (rwe && !wr) wb_q.push_back('{name, rd_i, exp_wb});
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      check({name, ":stall_ready"}, {31'd0, ready_Q103H},       32'd0);
      check({name, ":stall_req"},   {31'd0, dmem_req},          32'd1);
      check({name, ":stall_we"},    {31'd0, dmem_we},           {31'd0, wr});
      check({name, ":stall_addr"},  dmem_addr,                  exp_addr);
      check({name, ":stall_be"},    {28'd0, dmem_be},           {28'd0, exp_be});
      check({name, ":stall_wdata"}, dmem_wdata,                 exp_wdata);
      check({name, ":stall_to"},    {31'd0, err_timeout_Q103H}, 32'd0);
      if (chk_hold) check({name, ":q104_hold"}, wb_data_Q104H, hold_data);
      @(posedge clk); #1;
    end
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    @(negedge clk);
    check({name, ":ready"},    {31'd0, ready_Q103H},      32'd1);
    check({name, ":misalign"}, {31'd0, misaligned_Q103H}, 32'd0);
    if (rwe && !wr) check({name, ":wb_q103"}, wb_data_Q103H, exp_wb);
  endtask

  task automatic run_mis(input string name, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr);
    @(posedge clk); #1;
    drive_idle();
    valid        = 1'b1;
    mem_rd       = ~wr;
    mem_wr       = wr;
    mem_size     = size;
    alu_out      = addr;
    sel_wb       = 2'b01;
    rd           = 5'd20;
    reg_write_en = 1'b1;
    @(negedge clk);
    check({name, ":misalign"}, {31'd0, misaligned_Q103H}, 32'd1);
    check({name, ":req"},      {31'd0, dmem_req},         32'd0);
    check({name, ":ready"},    {31'd0, ready_Q103H},      32'd1);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check({name, ":q104_we"},  {31'd0, reg_write_en_Q104H}, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    check("rst:req",      {31'd0, dmem_req},           32'd0);
    check("rst:ready",    {31'd0, ready_Q103H},        32'd1);
    check("rst:wb_data",  wb_data_Q104H,               32'd0);
    check("rst:rd",       {27'd0, rd_Q104H},           32'd0);
    check("rst:we",       {31'd0, reg_write_en_Q104H}, 32'd0);
    check("rst:timeout",  {31'd0, err_timeout_Q103H},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Non-memory ops; an unaligned-looking ALU result must not flag misaligned.
    run_alu("alu",  2'b00, 32'h0000_0103, 32'h0000_1004, 5'd5, 32'h0000_0103);
    run_alu("pc4",  2'b10, 32'h1234_5678, 32'h0000_1004, 5'd1, 32'h0000_1004);

    // Load word, zero-wait ack.
    run_mem("ld_w_100", 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 0,
            32'hDEAD_BEEF, 32'h0000_0100, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0);

    // Signed byte load after an ALU op: three stall cycles, Q104H holds ALU result.
    run_alu("alu_pre", 2'b00, 32'h0000_0103, 32'h0, 5'd5, 32'h0000_0103);
    run_mem("ld_b_103", 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 5'd9, 1'b1, 3,
            32'h8011_2233, 32'h0000_0100, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b1, 32'h0000_0103);

    run_mem("ld_bu_101", 1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0, 5'd10, 1'b1, 0,
            32'h8011_2233, 32'h0000_0100, 4'b0010, 32'h0, 32'h0000_0022, 1'b0, 32'h0);
    run_mem("ld_h_202", 1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 5'd11, 1'b1, 1,
            32'h8011_2233, 32'h0000_0200, 4'b1100, 32'h0, 32'hFFFF_8011, 1'b0, 32'h0);
    run_mem("ld_hu_202", 1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 5'd12, 1'b1, 0,
            32'h8011_2233, 32'h0000_0200, 4'b1100, 32'h0, 32'h0000_8011, 1'b0, 32'h0);
    run_mem("ld_h_200", 1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'h0, 5'd13, 1'b1, 0,
            32'h1234_A5A5, 32'h0000_0200, 4'b0011, 32'h0, 32'hFFFF_A5A5, 1'b0, 32'h0);
    run_mem("ld_w11_104", 1'b0, 2'b11, 1'b0, 32'h0000_0104, 32'h0, 5'd14, 1'b1, 0,
            32'h0BAD_F00D, 32'h0000_0104, 4'b1111, 32'h0, 32'h0BAD_F00D, 1'b0, 32'h0);
    run_mem("ld_b_102_nowb", 1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0, 5'd15, 1'b0, 0,
            32'h8011_2233, 32'h0000_0100, 4'b0100, 32'h0, 32'h0, 1'b0, 32'h0);

    // Stores.
    run_mem("st_h_202", 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 5'd0, 1'b0, 0,
            32'h0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0, 32'h0);
    run_mem("st_b_301", 1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h0000_0055, 5'd0, 1'b0, 2,
            32'h0, 32'h0000_0300, 4'b0010, 32'h5555_5555, 32'h0, 1'b0, 32'h0);
    run_mem("st_w_400", 1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'hCAFE_F00D, 5'd0, 1'b0, 0,
            32'h0, 32'h0000_0400, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0, 32'h0);

    // Misaligned accesses.
    run_mis("mis_w_101", 1'b0, 2'b10, 32'h0000_0101);
    run_mis("mis_h_203", 1'b1, 2'b01, 32'h0000_0203);
    run_mis("mis_w11_102", 1'b0, 2'b11, 32'h0000_0102);

    // Reset during WAIT, followed by a late ack.
    @(posedge clk); #1;
    drive_idle();
    valid        = 1'b1;
    mem_rd       = 1'b1;
    mem_size     = 2'b10;
    alu_out      = 32'h0000_0500;
    sel_wb       = 2'b01;
    rd           = 5'd3;
    reg_write_en = 1'b1;
    @(negedge clk);
    check("rstw:req0",   {31'd0, dmem_req},    32'd1);
    check("rstw:ready0", {31'd0, ready_Q103H}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw:req1",   {31'd0, dmem_req},    32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rstw:req_after",   {31'd0, dmem_req},           32'd0);
    check("rstw:ready_after", {31'd0, ready_Q103H},        32'd1);
    check("rstw:q104_we",     {31'd0, reg_write_en_Q104H}, 32'd0);
    check("rstw:q104_data",   wb_data_Q104H,               32'd0);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("rstw:req_idle",    {31'd0, dmem_req},           32'd0);
    check("rstw:q104_we2",    {31'd0, reg_write_en_Q104H}, 32'd0);

    run_alu("alu_post_rst", 2'b00, 32'h0000_00A5, 32'h0, 5'd31, 32'h0000_00A5);

`ifdef RV_MEM_TIMEOUT_EN
    begin
      int cyc;
      @(posedge clk); #1;
      drive_idle();
      valid        = 1'b1;
      mem_rd       = 1'b1;
      mem_size     = 2'b10;
      alu_out      = 32'h0000_0600;
      sel_wb       = 2'b01;
      rd           = 5'd4;
      reg_write_en = 1'b1;
      cyc = 0;
      @(negedge clk);
      while (!err_timeout_Q103H && cyc < 20) begin
        @(posedge clk); #1;
        @(negedge clk);
        cyc++;
      end
      check("to:cycle",    cyc,                            32'd5);
      check("to:ready",    {31'd0, ready_Q103H},           32'd1);
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      check("to:pulse_end", {31'd0, err_timeout_Q103H},    32'd0);
      check("to:req_idle",  {31'd0, dmem_req},             32'd0);
      check("to:q104_we",   {31'd0, reg_write_en_Q104H},   32'd0);
    end
`else
    // Without the watchdog the access waits well past TIMEOUT_CYC.
    run_mem("ld_w_600_long", 1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0, 5'd4, 1'b1, 8,
            32'h600D_600D, 32'h0000_0600, 4'b1111, 32'h0, 32'h600D_600D, 1'b0, 32'h0);
`endif

    @(posedge clk); #1;
    drive_idle();
    repeat (3) @(negedge clk);
    check("end:wb_q_empty",  wb_q.size(),  32'd0);
    check("end:mem_q_empty", mem_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
